ram_access_ctrl: RTL



---
 rtl/ram_access_ctrl_pkg.sv | 18 +
 rtl/ram_access_ctrl_if.sv | 44 ++++
 rtl/ram_access_ctrl_rd_buf.sv | 61 ++++++
 rtl/ram_access_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM requester-side controllers: grant encoding
// and the read-buffer sizing rule.
package pkg_mem_ctrl;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  localparam int RAM_RD_LATENCY = 1;

  // One entry covers the read in flight in the RAM, one more holds the beat
  // being presented, which is what one-read-per-cycle streaming needs.
  function automatic int min_rd_buf_depth();
    return RAM_RD_LATENCY + 1;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request, response and native RAM port bundle of ram_access_ctrl.
// The controller is the slave of the requests and drives the RAM strobes.
interface ram_access_ctrl_if
  import pkg_mem_ctrl::*;
#(
  parameter int SRAM_WIDTH      = 128,
  parameter int SRAM_ADDR_WIDTH = 6
);

  logic                       wr_req_vld;
  logic                       wr_req_rdy;
  logic [SRAM_ADDR_WIDTH-1:0] wr_req_addr;
  logic [SRAM_WIDTH-1:0]      wr_req_data;

  logic                       rd_req_vld;
  logic                       rd_req_rdy;
  logic [SRAM_ADDR_WIDTH-1:0] rd_req_addr;

  logic                       rd_dat_vld;
  logic                       rd_dat_rdy;
  logic [SRAM_WIDTH-1:0]      rd_dat;

  logic [SRAM_ADDR_WIDTH-1:0] ram_addr_r;
  logic [SRAM_ADDR_WIDTH-1:0] ram_addr_w;
  logic                       ram_read_en;
  logic                       ram_write_en;
  logic [SRAM_WIDTH-1:0]      ram_data_in;
  logic [SRAM_WIDTH-1:0]      ram_data_out;

  modport master (
    output wr_req_vld, wr_req_addr, wr_req_data,
    output rd_req_vld, rd_req_addr, rd_dat_rdy, ram_data_out,
    input  wr_req_rdy, rd_req_rdy, rd_dat_vld, rd_dat,
    input  ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
  );

  modport slave (
    input  wr_req_vld, wr_req_addr, wr_req_data,
    input  rd_req_vld, rd_req_addr, rd_dat_rdy, ram_data_out,
    output wr_req_rdy, rd_req_rdy, rd_dat_vld, rd_dat,
    output ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
  );

endinterface

// File: rtl/ram_access_ctrl_rd_buf.sv
// Synchronous FIFO with push/pop/count, used to re-time RAM read data into a
// backpressured stream. Depth need not be a power of two.
module ram_rd_buf
  import pkg_mem_ctrl::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push  = push && (count != CNT_W'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Turns write/read valid-ready streams into native RAM strobes and re-times
// the one-cycle RAM read data into an in-order, backpressured response stream.
module ram_access_ctrl
  import pkg_mem_ctrl::*;
#(
  parameter int SRAM_WIDTH      = 128,
  parameter int SRAM_WORD       = 64,
  parameter int SRAM_ADDR_WIDTH = $clog2(SRAM_WORD),
  parameter int DUAL_PORT       = 0,
  parameter int RD_BUF_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_access_ctrl_if.slave bus
);

  localparam int BUF_DEPTH = (RD_BUF_DEPTH < min_rd_buf_depth()) ?
                             min_rd_buf_depth() : RD_BUF_DEPTH;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W     = CNT_W + 1;

  logic [CNT_W-1:0]      count;
  logic [OCC_W-1:0]      occupancy;
  logic [SRAM_WIDTH-1:0] rd_data;
  logic                  inflight;
  logic                  rd_vld;
  logic                  pop;
  logic                  rd_ok;
  logic                  wr_rdy;
  logic                  rd_rdy;
  logic                  wr_fire;
  logic                  rd_fire;

  // A read may issue only if the buffer can still absorb it once everything
  // already in flight has landed, counting the beat leaving this cycle.
  assign rd_vld    = (count != '0);
  assign pop       = rd_vld & bus.rd_dat_rdy;
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign rd_ok     = (occupancy < OCC_W'(BUF_DEPTH));

  assign wr_fire = bus.wr_req_vld & wr_rdy;
  assign rd_fire = bus.rd_req_vld & rd_rdy;

  assign bus.wr_req_rdy   = wr_rdy;
  assign bus.rd_req_rdy   = rd_rdy;
  assign bus.ram_write_en = wr_fire;
  assign bus.ram_read_en  = rd_fire;
  assign bus.ram_addr_w   = bus.wr_req_addr;
  assign bus.ram_addr_r   = bus.rd_req_addr;
  assign bus.ram_data_in  = bus.wr_req_data;
  assign bus.rd_dat_vld   = rd_vld;
  assign bus.rd_dat       = rd_data;

  if (DUAL_PORT != 0) begin : g_dual
    logic addr_clash;

    // Holding off a same-address read for one cycle lets it see the new data.
    assign addr_clash = bus.wr_req_vld && (bus.wr_req_addr == bus.rd_req_addr);
    assign wr_rdy     = 1'b1;
    assign rd_rdy     = rd_ok && !addr_clash;
  end else begin : g_single
    grant_t last_grant;

    assign wr_rdy = !bus.rd_req_vld || !rd_ok || (last_grant == GRANT_RD);
    assign rd_rdy = rd_ok && (!bus.wr_req_vld || (last_grant == GRANT_WR));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_grant <= GRANT_RD;
      end else if (wr_fire) begin
        last_grant <= GRANT_WR;
      end else if (rd_fire) begin
        last_grant <= GRANT_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_fire;
    end
  end

  ram_rd_buf #(
    .WIDTH (SRAM_WIDTH),
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_rd_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (bus.ram_data_out),
    .pop       (pop),
    .pop_data  (rd_data),
    .count     (count)
  );

endmodule
